// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned STATE_W       = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - bin, borrow out when a < b + bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = WIDTH - 1;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0] a_sh, a_sh_next;
  logic [WIDTH-1:0] b_sh, b_sh_next;
  // Result bits collected so far; the final bit comes straight from the subtractor.
  logic [RW-1:0]   res_sh, res_sh_next;
  logic            bq, bq_next;
  logic            busy_next, done_next;
  logic [WIDTH-1:0] diff_next;
  logic            borrow_next;
  logic            fs_diff, fs_borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic            ovf_next;
`endif

  // Per-bit arithmetic on the current LSBs and the stored borrow.
  full_subtractor u_fs (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .bin    (bq),
    .diff   (fs_diff),
    .borrow (fs_borrow)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    a_sh_next   = a_sh;
    b_sh_next   = b_sh;
    res_sh_next = res_sh;
    bq_next     = bq;
    diff_next   = diff;
    borrow_next = borrow;
`ifdef SERIAL_SUB_OVF_EN
    ovf_next    = ovf;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_sh_next  = a;
          b_sh_next  = b;
          bq_next    = bin;
          cnt_next   = '0;
          state_next = RUN;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        a_sh_next   = a_sh >> 1;
        b_sh_next   = b_sh >> 1;
        res_sh_next = RW'({fs_diff, res_sh} >> 1);
        bq_next     = fs_borrow;
        cnt_next    = cnt + CW'(1);
        if (cnt_next == CW'(WIDTH)) begin
          state_next  = DONE;
          diff_next   = {fs_diff, res_sh};
          borrow_next = fs_borrow;
`ifdef SERIAL_SUB_OVF_EN
          // At the last bit a_sh[0]/b_sh[0] hold the operand MSBs.
          ovf_next    = (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ fs_diff);
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      bq     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      a_sh   <= a_sh_next;
      b_sh   <= b_sh_next;
      res_sh <= res_sh_next;
      bq     <= bq_next;
      busy   <= busy_next;
      done   <= done_next;
      diff   <= diff_next;
      borrow <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= ovf_next;
`endif
    end
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new subtraction.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, sampled only on the accepting edge.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, sampled only on the accepting edge.
REQ-007 SHALL have port bin, input, 1 bit: initial borrow-in, sampled only on the accepting edge.
REQ-008 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port diff, output, WIDTH bits: registered result, equal to a - b - bin modulo 2^WIDTH.
REQ-011 SHALL have port borrow, output, 1 bit: registered final borrow, high exactly when a < b + bin (unsigned).
REQ-012 SHALL have port ovf, output, 1 bit: signed overflow; present only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 Accepting edge SHALL be an edge where start=1 and state is IDLE or DONE.
- On that edge: load the a/b shift registers, load the borrow flip-flop with bin, clear the bit counter, enter RUN.
REQ-015 start SHALL be ignored in RUN.
REQ-016 Each RUN edge SHALL process one bit, LSB first, as follows:
- Drive a_sh[0], b_sh[0] and the borrow flip-flop into one full_subtractor instance.
- Shift the diff bit into the result MSB and shift the result right.
- Shift the a/b registers right.
- Store the new borrow.
- Increment the counter.
REQ-017 After WIDTH RUN edges the state SHALL go RUN->DONE, and on that same edge diff, borrow and ovf SHALL be updated.
REQ-018 done SHALL be high only in DONE, i.e. for exactly one cycle, visible WIDTH edges after the accepting edge; DONE SHALL return to IDLE on the next edge unless start=1.
REQ-019 diff, borrow and ovf SHALL hold their values from the last completion through IDLE and the next RUN, until the next DONE entry.
REQ-020 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap; it reaching WIDTH is the sole exit condition from RUN.
REQ-021 When start=1 in DONE, done SHALL still pulse that cycle and the new operation SHALL begin (back-to-back), with busy rising on the next edge.

Reset
REQ-022 When rst_n=0 at an edge, the block SHALL do the following, overriding start:
- Enter IDLE.
- Clear busy, done, diff, borrow, ovf, the counter, the shift registers and the borrow flip-flop.
REQ-023 Reset during RUN SHALL abandon the operation; no done pulse is produced for it.

Configuration
REQ-024 With SERIAL_SUB_OVF_EN defined, ovf SHALL exist and, at DONE entry, SHALL be set to (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]) using the latched operands.
REQ-025 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the following; the module SHALL use them and not redefine them:
- The state typedef (IDLE, RUN, DONE) and its encoding width.
- The DEFAULT_WIDTH=8 constant.
REQ-027 The per-bit arithmetic SHALL be one instance of the existing full_subtractor (ports a, b, bin, diff, borrow); no other sub-module.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, bin=0, one-cycle start -> busy high for 8 cycles; done pulse 8 edges after accept; diff=0x02, borrow=0, ovf=0.
REQ-029 a=0x03, b=0x05, bin=0 -> diff=0xFE, borrow=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1.
REQ-030 a=0x80, b=0x01, bin=0 -> diff=0x7F, borrow=0, ovf=1 (macro defined); build without the macro has no ovf port.
REQ-031 start held high during RUN with different operands -> ignored; result matches the first operands; start held in DONE -> second result 8 edges after that DONE edge.
REQ-032 rst_n=0 for one edge after the 4th RUN edge -> state IDLE, all outputs 0, no done pulse; a fresh start then completes correctly.
